// File: rtl/cwc_capture_pkg.sv
// Shared types for the ChipWatcher capture engine.
package cwc_capture_pkg;

  localparam int unsigned CAP_STATE_W = 3;

  typedef enum logic [CAP_STATE_W-1:0] {
    IDLE      = 3'd0,
    PRE       = 3'd1,
    WAIT_TRIG = 3'd2,
    POST      = 3'd3,
    DONE      = 3'd4,
    READ      = 3'd5
  } cap_state_e;

endpackage

// File: rtl/cwc_capture_ctrl_if.sv
// Readout stream towards the debughub: valid/ready with a last marker.
interface cwc_capture_ctrl_if #(
  parameter int unsigned DATA_W = 167
);
  logic [DATA_W-1:0] dout;
  logic              dout_vld;
  logic              dout_rdy;
  logic              dout_last;

  modport master (output dout, output dout_vld, output dout_last, input dout_rdy);
  modport slave  (input dout, input dout_vld, input dout_last, output dout_rdy);
endinterface

// File: rtl/cwc_sample_ram.sv
// Simple dual-port sample RAM with a registered, enabled read port.
// No reset on purpose so it maps onto block RAM.
module cwc_sample_ram #(
  parameter int unsigned DATA_W = 167,
  parameter int unsigned DEPTH  = 16384,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [0:DEPTH-1];

  // Write port: store one probe sample per enabled cycle.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read port: rdata only changes when a read is issued, so it holds while stalled.
  always_ff @(posedge clk) begin
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/cwc_capture_ctrl.sv
// Capture controller: circular pre/post trigger capture into the sample RAM,
// then oldest-first readout through a one-deep RAM stage plus output register.
module cwc_capture_ctrl
  import cwc_capture_pkg::*;
#(
  parameter int unsigned DATA_W = 167,
  parameter int unsigned DEPTH  = 16384,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      arm,
  input  logic                      abort,
  input  logic [ADDR_W-1:0]         trig_pos,
  input  logic [DATA_W-1:0]         din,
  input  logic                      din_vld,
  input  logic                      trig,
  input  logic                      rd_start,
  cwc_capture_ctrl_if.master        rd_if,
  output logic                      busy,
  output logic                      triggered,
  output logic                      done,
  output logic [ADDR_W-1:0]         trig_addr
);

  cap_state_e state_q, state_d;
  logic busy_q, busy_d, done_q, done_d;

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] pre_cnt_q, pre_cnt_d;
  logic [ADDR_W-1:0] post_cnt_q, post_cnt_d;
  logic [ADDR_W-1:0] trig_pos_q, trig_pos_d;
  logic [ADDR_W-1:0] trig_addr_q, trig_addr_d;
  logic              triggered_q, triggered_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   rd_cnt_q, rd_cnt_d;
  logic              ram_vld_q, ram_vld_d;
  logic              ram_last_q, ram_last_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              dout_vld_q, dout_vld_d;
  logic              dout_last_q, dout_last_d;

  logic              capturing_s, arm_s, write_s, trig_hit_s, pre_hit_s, post_hit_s;
  logic              out_free_s, load_s, issue_s, last_acc_s;
  logic [ADDR_W-1:0] post_init_s;
  logic [DATA_W-1:0] ram_rdata_s;

  // Event decode shared by the FSM and the datapath.
  always_comb begin
    capturing_s = (state_q == PRE) || (state_q == WAIT_TRIG) || (state_q == POST);
    arm_s       = arm && (state_q != READ) && !abort;
    write_s     = capturing_s && din_vld && !abort && !arm_s;
    trig_hit_s  = write_s && (state_q == WAIT_TRIG) && trig;
    pre_hit_s   = write_s && (state_q == PRE) && ((pre_cnt_q + ADDR_W'(1)) == trig_pos_q);
    post_hit_s  = write_s && (state_q == POST) && (post_cnt_q == ADDR_W'(1));
    post_init_s = ADDR_W'(DEPTH - 1) - trig_pos_q;
    out_free_s  = !dout_vld_q || rd_if.dout_rdy;
    load_s      = (state_q == READ) && ram_vld_q && out_free_s;
    issue_s     = (state_q == READ) && !rd_cnt_q[ADDR_W] && (!ram_vld_q || out_free_s);
    last_acc_s  = (state_q == READ) && dout_vld_q && rd_if.dout_rdy && dout_last_q;
  end

  // FSM state register plus registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // FSM next state: abort beats arm, arm beats everything else.
  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = IDLE;
    end else if (arm_s) begin
      state_d = (trig_pos != ADDR_W'(0)) ? PRE : WAIT_TRIG;
    end else begin
      case (state_q)
        IDLE:      state_d = IDLE;
        PRE:       state_d = pre_hit_s ? WAIT_TRIG : PRE;
        WAIT_TRIG: begin
          if (trig_hit_s) begin
            state_d = (post_init_s == ADDR_W'(0)) ? DONE : POST;
          end else begin
            state_d = WAIT_TRIG;
          end
        end
        POST:      state_d = post_hit_s ? DONE : POST;
        DONE:      state_d = rd_start ? READ : DONE;
        READ:      state_d = last_acc_s ? DONE : READ;
        default:   state_d = IDLE;
      endcase
    end
  end

  // FSM outputs, computed from the next state so they register in step with it.
  always_comb begin
    busy_d = 1'b0;
    done_d = 1'b0;
    case (state_d)
      PRE, WAIT_TRIG, POST: busy_d = 1'b1;
      DONE:                 done_d = 1'b1;
      default: begin
        busy_d = 1'b0;
        done_d = 1'b0;
      end
    endcase
  end

  // Datapath next values: write pointer, window counters and readout pipeline.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    pre_cnt_d   = pre_cnt_q;
    post_cnt_d  = post_cnt_q;
    trig_pos_d  = trig_pos_q;
    trig_addr_d = trig_addr_q;
    triggered_d = triggered_q;
    rd_ptr_d    = rd_ptr_q;
    rd_cnt_d    = rd_cnt_q;
    ram_vld_d   = ram_vld_q;
    ram_last_d  = ram_last_q;
    dout_d      = dout_q;
    dout_vld_d  = dout_vld_q;
    dout_last_d = dout_last_q;
    if (abort) begin
      triggered_d = 1'b0;
      dout_vld_d  = 1'b0;
      dout_last_d = 1'b0;
      ram_vld_d   = 1'b0;
    end else if (arm_s) begin
      wr_ptr_d    = ADDR_W'(0);
      pre_cnt_d   = ADDR_W'(0);
      triggered_d = 1'b0;
      trig_pos_d  = trig_pos;
    end else begin
      if (write_s) begin
        wr_ptr_d = wr_ptr_q + ADDR_W'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (write_s && (state_q == PRE)) begin
        pre_cnt_d = pre_cnt_q + ADDR_W'(1);
      end else begin
        pre_cnt_d = pre_cnt_q;
      end
      if (trig_hit_s) begin
        trig_addr_d = wr_ptr_q;
        triggered_d = 1'b1;
        post_cnt_d  = post_init_s;
      end else if (write_s && (state_q == POST)) begin
        post_cnt_d = post_cnt_q - ADDR_W'(1);
      end else begin
        post_cnt_d = post_cnt_q;
      end
      if ((state_q == DONE) && rd_start) begin
        // Oldest sample of the window sits trig_pos entries before the trigger.
        rd_ptr_d   = trig_addr_q - trig_pos_q;
        rd_cnt_d   = '0;
        ram_vld_d  = 1'b0;
        ram_last_d = 1'b0;
      end else if (state_q == READ) begin
        if (issue_s) begin
          rd_ptr_d   = rd_ptr_q + ADDR_W'(1);
          rd_cnt_d   = rd_cnt_q + (ADDR_W+1)'(1);
          ram_last_d = (rd_cnt_q == (ADDR_W+1)'(DEPTH - 1));
        end else begin
          rd_ptr_d   = rd_ptr_q;
          rd_cnt_d   = rd_cnt_q;
          ram_last_d = ram_last_q;
        end
        if (load_s) begin
          dout_d      = ram_rdata_s;
          dout_vld_d  = 1'b1;
          dout_last_d = ram_last_q;
        end else if (out_free_s) begin
          dout_vld_d  = 1'b0;
          dout_last_d = 1'b0;
        end else begin
          dout_vld_d  = dout_vld_q;
          dout_last_d = dout_last_q;
        end
        if (issue_s) begin
          ram_vld_d = 1'b1;
        end else if (load_s) begin
          ram_vld_d = 1'b0;
        end else begin
          ram_vld_d = ram_vld_q;
        end
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      pre_cnt_q   <= '0;
      post_cnt_q  <= '0;
      trig_pos_q  <= '0;
      trig_addr_q <= '0;
      triggered_q <= 1'b0;
      rd_ptr_q    <= '0;
      rd_cnt_q    <= '0;
      ram_vld_q   <= 1'b0;
      ram_last_q  <= 1'b0;
      dout_q      <= '0;
      dout_vld_q  <= 1'b0;
      dout_last_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      pre_cnt_q   <= pre_cnt_d;
      post_cnt_q  <= post_cnt_d;
      trig_pos_q  <= trig_pos_d;
      trig_addr_q <= trig_addr_d;
      triggered_q <= triggered_d;
      rd_ptr_q    <= rd_ptr_d;
      rd_cnt_q    <= rd_cnt_d;
      ram_vld_q   <= ram_vld_d;
      ram_last_q  <= ram_last_d;
      dout_q      <= dout_d;
      dout_vld_q  <= dout_vld_d;
      dout_last_q <= dout_last_d;
    end
  end

  cwc_sample_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (write_s),
    .waddr (wr_ptr_q),
    .wdata (din),
    .re    (issue_s),
    .raddr (rd_ptr_q),
    .rdata (ram_rdata_s)
  );

  assign busy            = busy_q;
  assign done            = done_q;
  assign triggered       = triggered_q;
  assign trig_addr       = trig_addr_q;
  assign rd_if.dout      = dout_q;
  assign rd_if.dout_vld  = dout_vld_q;
  assign rd_if.dout_last = dout_last_q;

endmodule

// File: tb/tb_cwc_capture_ctrl.sv
// Bench for cwc_capture_ctrl (DEPTH=16). The reference model keeps the list of
// stored samples; the expected window is simply the last DEPTH stored samples.
module tb_cwc_capture_ctrl;

  localparam int DATA_W = 167;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  logic              clk = 1'b0;
  logic              rst, arm, abort, din_vld, trig, rd_start;
  logic [ADDR_W-1:0] trig_pos;
  logic [DATA_W-1:0] din;
  logic              busy, triggered, done;
  logic [ADDR_W-1:0] trig_addr;

  cwc_capture_ctrl_if #(.DATA_W(DATA_W)) rd_if ();

  cwc_capture_ctrl #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .arm(arm), .abort(abort), .trig_pos(trig_pos),
    .din(din), .din_vld(din_vld), .trig(trig), .rd_start(rd_start),
    .rd_if(rd_if), .busy(busy), .triggered(triggered), .done(done),
    .trig_addr(trig_addr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model
  int samples[$];
  int wcount, trig_idx, m_tp, din_cnt;
  bit m_done;

  task automatic arm_capture(input int tp, input bit with_rd);
    trig_pos = ADDR_W'(tp);
    arm = 1'b1; rd_start = with_rd; din_vld = 1'b0; trig = 1'b0;
    @(posedge clk); #1;
    arm = 1'b0; rd_start = 1'b0;
    samples.delete(); wcount = 0; trig_idx = -1; m_tp = tp; din_cnt = 0; m_done = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL arm_busy got %0b exp 1", busy); end
    checks++; if (done !== 1'b0 || triggered !== 1'b0) begin errors++; $display("FAIL arm_flags done %0b trig %0b exp 0 0", done, triggered); end
  endtask

  task automatic cap_cycle(input bit vld, input bit tg);
    din = DATA_W'(din_cnt); din_vld = vld; trig = tg;
    @(posedge clk); #1;
    if (!m_done && vld) begin
      samples.push_back(din_cnt);
      if (trig_idx < 0 && tg && wcount >= m_tp) trig_idx = wcount;
      wcount++;
      if (trig_idx >= 0 && wcount == trig_idx + DEPTH - m_tp) m_done = 1'b1;
    end
    din_cnt++; din_vld = 1'b0; trig = 1'b0;
    checks++; if (triggered !== (trig_idx >= 0)) begin errors++; $display("FAIL cap_triggered got %0b exp %0b din %0d", triggered, (trig_idx >= 0), din_cnt - 1); end
    checks++; if (done !== m_done) begin errors++; $display("FAIL cap_done got %0b exp %0b din %0d", done, m_done, din_cnt - 1); end
    checks++; if (busy !== !m_done) begin errors++; $display("FAIL cap_busy got %0b exp %0b din %0d", busy, !m_done, din_cnt - 1); end
    if (trig_idx >= 0) begin
      checks++; if (trig_addr !== ADDR_W'(trig_idx % DEPTH)) begin errors++; $display("FAIL cap_trig_addr got %0d exp %0d", trig_addr, trig_idx % DEPTH); end
    end
  endtask

  // trig_at: >=0 trigger on that din value, -1 held high, -2 random
  task automatic run_capture(input int tp, input int trig_at, input int vld_pct, input bit with_rd);
    bit v, t;
    arm_capture(tp, with_rd);
    for (int c = 0; c < 400 && !m_done; c++) begin
      v = ($urandom_range(99) < vld_pct);
      if (trig_at == -1) t = 1'b1;
      else if (trig_at == -2) t = ($urandom_range(7) == 0);
      else t = (din_cnt == trig_at);
      cap_cycle(v, t);
    end
    checks++; if (!m_done) begin errors++; $display("FAIL cap_timeout done %0b exp 1", done); end
  endtask

  // rdy_mode: 0 always ready, 1 pattern 1,0,0,1, 2 random
  task automatic readout(input int rdy_mode);
    int exp_q[$];
    int got, k, base;
    bit seen, prev_stall, r;
    logic [DATA_W-1:0] prev_d;
    logic [3:0] pat;
    pat = 4'b1001;
    base = samples.size() - DEPTH;
    for (int i = 0; i < DEPTH; i++) exp_q.push_back(samples[base + i]);
    rd_start = 1'b1;
    @(posedge clk); #1;
    rd_start = 1'b0;
    got = 0; k = 0; seen = 1'b0; prev_stall = 1'b0; prev_d = '0;
    while (got < DEPTH && k < 200) begin
      if (rd_if.dout_vld === 1'b1 && !seen) begin
        seen = 1'b1;
        checks++; if (k != 2) begin errors++; $display("FAIL rd_latency got %0d exp 2", k); end
      end
      if (prev_stall) begin
        checks++; if (rd_if.dout_vld !== 1'b1 || rd_if.dout !== prev_d) begin errors++; $display("FAIL rd_hold got vld %0b d %0d exp vld 1 d %0d", rd_if.dout_vld, rd_if.dout, prev_d); end
      end
      if (rdy_mode == 0) r = 1'b1;
      else if (rdy_mode == 1) r = pat[k % 4];
      else r = $urandom_range(1);
      rd_if.dout_rdy = r;
      if (rd_if.dout_vld === 1'b1 && r) begin
        checks++; if (rd_if.dout !== DATA_W'(exp_q[got])) begin errors++; $display("FAIL rd_data idx %0d got %0d exp %0d", got, rd_if.dout, exp_q[got]); end
        checks++; if (rd_if.dout_last !== (got == DEPTH - 1)) begin errors++; $display("FAIL rd_last idx %0d got %0b exp %0b", got, rd_if.dout_last, (got == DEPTH - 1)); end
        got++;
      end
      prev_stall = (rd_if.dout_vld === 1'b1) && !r;
      prev_d = rd_if.dout;
      @(posedge clk); #1;
      k++;
    end
    rd_if.dout_rdy = 1'b0;
    checks++; if (got != DEPTH) begin errors++; $display("FAIL rd_count got %0d exp %0d", got, DEPTH); end
    checks++; if (rd_if.dout_vld !== 1'b0 || done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL rd_end vld %0b done %0b busy %0b exp 0 1 0", rd_if.dout_vld, done, busy); end
  endtask

  task automatic test_reset();
    rst = 1'b1; arm = 1'b0; abort = 1'b0; din_vld = 1'b0; trig = 1'b0; rd_start = 1'b0;
    trig_pos = '0; din = '0; rd_if.dout_rdy = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if ({busy, triggered, done, rd_if.dout_vld, rd_if.dout_last} !== 5'b0) begin errors++; $display("FAIL reset_flags got %b exp 00000", {busy, triggered, done, rd_if.dout_vld, rd_if.dout_last}); end
    checks++; if (trig_addr !== '0 || rd_if.dout !== '0) begin errors++; $display("FAIL reset_data trig_addr %0d dout %0d exp 0 0", trig_addr, rd_if.dout); end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    run_capture(4, 20, 100, 1'b0);
    checks++; if (trig_addr !== 4'd4) begin errors++; $display("FAIL basic_trig_addr got %0d exp 4", trig_addr); end
    checks++; if (din_cnt - 1 != 31) begin errors++; $display("FAIL basic_done_din got %0d exp 31", din_cnt - 1); end
    readout(0);
  endtask

  task automatic test_trig_pos_zero();
    run_capture(0, 0, 100, 1'b0);
    checks++; if (trig_addr !== 4'd0) begin errors++; $display("FAIL tp0_trig_addr got %0d exp 0", trig_addr); end
    readout(2);
  endtask

  task automatic test_trig_pos_max();
    run_capture(15, -1, 100, 1'b0);
    checks++; if (trig_addr !== 4'd15 || din_cnt - 1 != 15) begin errors++; $display("FAIL tp15 trig_addr %0d done_din %0d exp 15 15", trig_addr, din_cnt - 1); end
    readout(0);
  endtask

  task automatic test_abort();
    arm_capture(4, 1'b0);
    for (int c = 0; c < 60 && (trig_idx < 0 || wcount < trig_idx + 3); c++) cap_cycle(1'b1, din_cnt == 20);
    abort = 1'b1; din = DATA_W'(din_cnt); din_vld = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0; din_vld = 1'b0;
    checks++; if ({busy, triggered, done} !== 3'b000) begin errors++; $display("FAIL abort_flags got %b exp 000", {busy, triggered, done}); end
    rd_start = 1'b1; rd_if.dout_rdy = 1'b1;
    @(posedge clk); #1;
    rd_start = 1'b0;
    for (int c = 0; c < 4; c++) begin
      checks++; if (rd_if.dout_vld !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL abort_rd vld %0b done %0b exp 0 0", rd_if.dout_vld, done); end
      @(posedge clk); #1;
    end
    rd_if.dout_rdy = 1'b0;
  endtask

  task automatic test_stall_readout();
    run_capture(4, -2, 100, 1'b0);
    readout(1);
  endtask

  task automatic test_back_to_back();
    run_capture(7, -2, 100, 1'b0);
    readout(0);
    readout(2);
    // arm and rd_start together in DONE: arm must win
    run_capture(2, -2, 100, 1'b1);
    readout(1);
  endtask

  task automatic test_din_vld_toggle();
    run_capture(4, -2, 50, 1'b0);
    readout(0);
  endtask

  task automatic test_async_rst();
    arm_capture(4, 1'b0);
    for (int c = 0; c < 200 && trig_idx < 0; c++) cap_cycle($urandom_range(1), $urandom_range(3) == 0);
    cap_cycle(1'b1, 1'b0);
    #2 rst = 1'b1;
    #1;
    checks++; if ({busy, triggered, done, rd_if.dout_vld, rd_if.dout_last} !== 5'b0 || trig_addr !== '0) begin errors++; $display("FAIL async_rst flags %b trig_addr %0d exp 00000 0", {busy, triggered, done, rd_if.dout_vld, rd_if.dout_last}, trig_addr); end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL async_rst_after busy %0b done %0b exp 0 0", busy, done); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 4; i++) begin
      run_capture($urandom_range(15), -2, 40 + $urandom_range(60), 1'b0);
      readout(2);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_trig_pos_zero();
    test_trig_pos_max();
    test_abort();
    test_stall_readout();
    test_back_to_back();
    test_din_vld_toggle();
    test_async_rst();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cwc_capture_ctrl.md
Name: cwc_capture_ctrl

Overview:
- Capture engine downstream of the ChipWatcher trigger hub.
- Stores the concatenated probe bus into a circular sample RAM with a programmable pre-trigger depth.
- Stops after the post-trigger window is full, then streams the window out oldest-first over a valid/ready port to the debughub readout path.
- One clock domain: the probe/trigger clock.

Parameters:
- DATA_W, 167, probe sample width (sum of all probe widths).
- DEPTH, 16384, samples per capture; power of two, min 4.
- ADDR_W, $clog2(DEPTH), RAM address / counter width.

Ports:
- clk  in  1  probe/trigger clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- arm  in  1  one-cycle pulse: start a new capture.
- abort  in  1  one-cycle pulse: return to IDLE from any state.
- trig_pos  in  ADDR_W  pre-trigger sample count; sampled on accepted arm.
- din  in  DATA_W  probe sample.
- din_vld  in  1  sample enable (storage qualifier).
- trig  in  1  trigger condition from hub; meaningful only when din_vld=1.
- rd_start  in  1  pulse: begin readout (accepted only in DONE).
- dout  out  DATA_W  readout sample.
- dout_vld  out  1  dout valid.
- dout_rdy  in  1  consumer ready.
- dout_last  out  1  marks the DEPTH-th readout sample.
- busy  out  1  state is PRE, WAIT_TRIG or POST.
- triggered  out  1  trigger accepted in current capture.
- done  out  1  state is DONE.
- trig_addr  out  ADDR_W  RAM address of the trigger sample.

Behaviour:
- Reset values:
  - state = IDLE.
  - All outputs 0; dout = 0.
  - Internal pointers and counters = 0.
- States:
  - IDLE: waits for arm.
  - PRE: filling the pre-trigger window.
  - WAIT_TRIG: pre-trigger window full, waiting for trigger.
  - POST: filling the post-trigger window.
  - DONE: capture complete, holding data.
  - READ: streaming the window out.
- Arm:
  - In IDLE, PRE, WAIT_TRIG, POST or DONE: clears wr_ptr, pre_cnt and triggered; latches trig_pos_q.
  - Next state is PRE if trig_pos != 0, else WAIT_TRIG.
  - Ignored in READ.
- Abort:
  - Takes priority over every other input.
  - Next state IDLE; clears triggered, dout_vld and done.
- Write rule: in PRE, WAIT_TRIG and POST, every din_vld cycle writes din to ram[wr_ptr], then wr_ptr increments modulo DEPTH (wrap, no stall).
- PRE:
  - Trigger ignored.
  - pre_cnt increments per write; on the write where pre_cnt+1 == trig_pos_q, move to WAIT_TRIG.
- WAIT_TRIG:
  - Writes wrap continuously.
  - On din_vld && trig: that sample is written; trig_addr <= wr_ptr; triggered <= 1; post_cnt <= DEPTH-1-trig_pos_q.
  - Next state DONE if post_cnt is 0, else POST.
- POST:
  - Trigger ignored.
  - post_cnt decrements per write; on the write that brings it to 0, move to DONE.
  - Samples after the trigger, including the trigger sample, total DEPTH - trig_pos_q.
- DONE:
  - done = 1; RAM contents frozen.
  - rd_start -> READ with rd_ptr = trig_addr - trig_pos_q (mod DEPTH) and rd_cnt = 0.
- READ:
  - RAM read latency is 1 cycle.
  - A prefetch output register gives 1 sample/cycle while dout_rdy=1.
  - First dout_vld occurs 2 cycles after rd_start.
  - dout and dout_vld hold stable while dout_vld && !dout_rdy.
  - dout_last = 1 on sample index DEPTH-1.
  - After that sample is accepted, return to DONE. Readout may be repeated.
- din_vld=0 cycles: no write, no counter change, trigger ignored.
- rd_start outside DONE: ignored.
- arm and rd_start in the same cycle in DONE: arm wins.
- The RAM has no reset; its contents are undefined until written.

Decomposition:
- Package cwc_capture_pkg:
  - state enum cap_state_e {IDLE, PRE, WAIT_TRIG, POST, DONE, READ}.
  - Localparams for state encoding width.
- Sub-module cwc_sample_ram:
  - Simple dual-port RAM, DATA_W x DEPTH, 1-cycle registered read, write-first not required.
  - Inferred to block RAM.
- cwc_capture_ctrl holds the FSM, pointers, counters and the output skid register.

Test Plan (DEPTH=16, din = incrementing counter starting at 0, din_vld=1 unless noted):
- trig_pos=4; arm; trig asserted with din=20 -> trig_addr=4; done after din=31; readout 16 samples = 16..31; dout_last on 31.
- trig_pos=0; arm; trig on the first sample (din=0) -> readout = 0..15; triggered=1 one cycle after the trigger sample.
- trig_pos=15; trig held high from arm -> trigger ignored during PRE; trigger accepted on din=15; done the same cycle +1; readout = 0..15.
- trig_pos=4; abort during POST -> IDLE next cycle; busy=0, triggered=0, done=0; a subsequent rd_start is ignored (dout_vld stays 0).
- Readout with dout_rdy toggling 1,0,0,1 each sample -> dout stable while stalled; exactly 16 accepts; no duplicates or skips; back to DONE.
- din_vld toggling 50% with trig_pos=4 -> only valid samples stored; readout is the same contiguous sequence of valid values; async rst mid-POST clears all outputs immediately.
